// File: rtl/phase_seq_monitor.sv
// phase_seq_monitor
//   Downstream checker for a 4-output pulse divider. Watches the divider's
//   phase bus, verifies the ring order 0->1->2->3->0, counts complete
//   rotations and flags order, collision and stall faults.
//
//   Optional feature macro: PHASE_SEQ_MON_IRQ_EN
//     defined     : irq pulses one cycle when err rises or cycle_cnt wraps
//     not defined : irq is tied to 0 (port list unchanged)
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low
//   clr        in   1      synchronous clear of fault/count/timer, back to IDLE
//   phase_in   in   4      divider phase bus
//   locked     out  1      1 while tracking the ring
//   err        out  1      sticky fault flag
//   err_code   out  2      first fault: 00 none, 01 order, 10 stall, 11 collision
//   cur_phase  out  2      index of next expected phase
//   cycle_cnt  out  CNT_W  completed rotations (wraps)
//   irq        out  1      one-cycle event pulse
module phase_seq_monitor #(
    parameter int CNT_W   = 16,
    parameter int TO_W    = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [3:0]       phase_in,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [1:0]       cur_phase,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      prev;
    logic [TO_W-1:0] timer;

    logic [3:0] rise;
    logic       multi;
    logic       hit;
    logic       in_track;
    logic       fault_ev;
    logic       stall_ev;

    assign rise     = phase_in & ~prev;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi    = |(rise & (rise - 4'd1));
    // hit can only be true for a one-hot rise, so it never overlaps multi.
    assign hit      = (rise == (4'b0001 << cur_phase));
    assign in_track = (state == TRACK);
    // Any non-zero rise that is not the expected phase is a fault;
    // multi selects collision versus order for the code.
    assign fault_ev = in_track && (rise != 4'b0000) && !hit;
    assign stall_ev = in_track && (rise == 4'b0000) && (timer == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prev      <= 4'b0000;
            timer     <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            cur_phase <= 2'd0;
            cycle_cnt <= '0;
        end else begin
            // Edge history always follows the bus, even during clr, so a
            // level held across clr does not produce a stale rise later.
            prev <= phase_in;
            if (clr) begin
                state     <= IDLE;
                timer     <= '0;
                locked    <= 1'b0;
                err       <= 1'b0;
                err_code  <= 2'b00;
                cur_phase <= 2'd0;
                cycle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise == 4'b0001) begin
                            state     <= TRACK;
                            locked    <= 1'b1;
                            cur_phase <= 2'd1;
                            timer     <= '0;
                        end
                    end
                    TRACK: begin
                        if (fault_ev) begin
                            state  <= FAULT;
                            locked <= 1'b0;
                            err    <= 1'b1;
                            if (!err) err_code <= multi ? 2'b11 : 2'b01;
                        end else if (hit) begin
                            cur_phase <= cur_phase + 2'd1;
                            timer     <= '0;
                            if (cur_phase == 2'd3) cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end else if (stall_ev) begin
                            state  <= IDLE;
                            locked <= 1'b0;
                            err    <= 1'b1;
                            timer  <= '0;
                            if (!err) err_code <= 2'b10;
                        end else begin
                            timer <= timer + TO_W'(1);
                        end
                    end
                    default: begin
                        // FAULT: parked until clr, all edges ignored.
                        state  <= FAULT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PHASE_SEQ_MON_IRQ_EN
    logic wrap_ev;
    logic irq_ev;

    assign wrap_ev = in_track && hit && (cur_phase == 2'd3) && (cycle_cnt == '1);
    // err 0->1 and a wrap in the same cycle merge into one pulse.
    assign irq_ev  = !clr && ((!err && (fault_ev || stall_ev)) || wrap_ev);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else        irq <= irq_ev;
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_phase_seq_monitor.sv
module tb_phase_seq_monitor;
    localparam int CNT_W   = 4;
    localparam int TO_W    = 5;
    localparam int TIMEOUT = 15;
    localparam int VW      = 7 + CNT_W;
`ifdef PHASE_SEQ_MON_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             clr;
    logic [3:0]       phase_in;
    logic             locked;
    logic             err;
    logic [1:0]       err_code;
    logic [1:0]       cur_phase;
    logic [CNT_W-1:0] cycle_cnt;
    logic             irq;

    phase_seq_monitor #(.CNT_W(CNT_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clr(clr), .phase_in(phase_in),
        .locked(locked), .err(err), .err_code(err_code), .cur_phase(cur_phase),
        .cycle_cnt(cycle_cnt), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 waiting, 1 tracking, 2 parked on a fault.
    logic [3:0] m_prev;
    int         m_mode, m_exp, m_cnt, m_quiet;
    bit         m_err, m_irq;
    logic [1:0] m_code;

    function automatic void model_reset();
        m_prev = 4'b0000; m_mode = 0; m_exp = 0; m_cnt = 0; m_quiet = 0;
        m_err = 1'b0; m_irq = 1'b0; m_code = 2'b00;
    endfunction

    function automatic void model_step(input logic [3:0] ph, input logic c);
        logic [3:0] r;
        bit was_err, wrapped;
        int ones;
        r = ph & ~m_prev;
        m_prev = ph;
        ones = $countones(r);
        was_err = m_err;
        wrapped = 1'b0;
        if (c) begin
            m_mode = 0; m_exp = 0; m_cnt = 0; m_quiet = 0; m_err = 1'b0; m_code = 2'b00;
        end else if (m_mode == 0) begin
            if (r == 4'b0001) begin m_mode = 1; m_exp = 1; m_quiet = 0; end
        end else if (m_mode == 1) begin
            if (ones > 1) begin
                m_mode = 2; if (!m_err) m_code = 2'b11; m_err = 1'b1;
            end else if (ones == 1 && $clog2(r) == m_exp) begin
                if (m_exp == 3) begin
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    wrapped = (m_cnt == 0);
                end
                m_exp = (m_exp + 1) % 4;
                m_quiet = 0;
            end else if (ones == 1) begin
                m_mode = 2; if (!m_err) m_code = 2'b01; m_err = 1'b1;
            end else if (m_quiet + 1 == TIMEOUT) begin
                m_mode = 0; m_quiet = 0; if (!m_err) m_code = 2'b10; m_err = 1'b1;
            end else begin
                m_quiet++;
            end
        end
        m_irq = IRQ_EN && ((m_err && !was_err) || wrapped);
    endfunction

    function automatic logic [VW-1:0] mexp();
        logic [1:0] e;
        logic [CNT_W-1:0] cn;
        e = m_exp[1:0];
        cn = m_cnt[CNT_W-1:0];
        return {(m_mode == 1), m_err, m_code, e, cn, m_irq};
    endfunction

    logic [VW-1:0] obs;
    always_comb obs = {locked, err, err_code, cur_phase, cycle_cnt, irq};

    task automatic step(input logic [3:0] ph, input logic c);
        phase_in = ph;
        clr = c;
        @(posedge clk);
        model_step(ph, c);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; clr = 1'b0; phase_in = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== '0) $display("FAIL reset_state: got %h want %h", obs, {VW{1'b0}});
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_ring();
        logic [3:0] ring [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int rot = 0; rot < 3; rot++)
            for (int p = 0; p < 4; p++)
                for (int k = 0; k < 2; k++) begin
                    step(ring[p], 1'b0);
                    n_checks++;
                    if (obs !== mexp()) $display("FAIL ring r%0d p%0d: got %h want %h", rot, p, obs, mexp());
                    else n_pass++;
                    if (rot == 0 && p == 0 && k == 0) begin
                        n_checks++;
                        if (locked !== 1'b1) $display("FAIL ring_lock_latency: got %b want 1", locked);
                        else n_pass++;
                    end
                end
        n_checks++;
        if ({cycle_cnt, err, cur_phase} !== {4'd3, 1'b0, 2'd0})
            $display("FAIL ring_final: got cnt=%0d err=%b ph=%0d want cnt=3 err=0 ph=0", cycle_cnt, err, cur_phase);
        else n_pass++;
    endtask

    task automatic test_order();
        logic [3:0] seq [6] = '{4'b0000, 4'b0001, 4'b0100, 4'b0010, 4'b0000, 4'b1000};
        step(4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(seq[i], 1'b0);
            n_checks++;
            if (obs !== mexp()) $display("FAIL order step%0d: got %h want %h", i, obs, mexp());
            else n_pass++;
        end
        n_checks++;
        if ({err, err_code, locked} !== {1'b1, 2'b01, 1'b0})
            $display("FAIL order_code: got err=%b code=%b locked=%b want 1 01 0", err, err_code, locked);
        else n_pass++;
        step(4'b0001, 1'b1);
        n_checks++;
        if ({err, err_code, cycle_cnt, locked} !== {1'b0, 2'b00, 4'd0, 1'b0})
            $display("FAIL order_clr: got err=%b code=%b cnt=%0d locked=%b want 0 00 0 0", err, err_code, cycle_cnt, locked);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [3:0] seq [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b1111};
        step(4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1'b0);
            n_checks++;
            if (obs !== mexp()) $display("FAIL collision step%0d: got %h want %h", i, obs, mexp());
            else n_pass++;
        end
        n_checks++;
        if ({err, err_code, locked, cur_phase} !== {1'b1, 2'b11, 1'b0, 2'd2})
            $display("FAIL collision_code: got err=%b code=%b locked=%b ph=%0d want 1 11 0 2", err, err_code, locked, cur_phase);
        else n_pass++;
    endtask

    task automatic test_stall();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) begin
            step(4'b0010, 1'b0);
            n_checks++;
            if (obs !== mexp()) $display("FAIL stall quiet%0d: got %h want %h", i, obs, mexp());
            else n_pass++;
        end
        n_checks++;
        if ({locked, err, err_code} !== {1'b0, 1'b1, 2'b10})
            $display("FAIL stall_code: got locked=%b err=%b code=%b want 0 1 10", locked, err, err_code);
        else n_pass++;
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b0);
        n_checks++;
        if ({locked, err, err_code} !== {1'b1, 1'b1, 2'b10})
            $display("FAIL stall_relock: got locked=%b err=%b code=%b want 1 1 10", locked, err, err_code);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int pulses = 0;
        step(4'b0000, 1'b1);
        for (int i = 0; i < 16 * 4; i++) begin
            logic [3:0] ph;
            ph = 4'b0001 << (i % 4);
            step(ph, 1'b0);
            if (irq === 1'b1) pulses++;
            n_checks++;
            if (obs !== mexp()) $display("FAIL wrap step%0d: got %h want %h", i, obs, mexp());
            else n_pass++;
        end
        step(4'b0001, 1'b0);
        if (irq === 1'b1) pulses++;
        n_checks++;
        if (cycle_cnt !== 4'd0 || pulses !== (IRQ_EN ? 1 : 0))
            $display("FAIL wrap_final: got cnt=%0d irq_pulses=%0d want cnt=0 irq_pulses=%0d", cycle_cnt, pulses, IRQ_EN ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [3:0] ph;
            logic c;
            r = $urandom_range(0, 99);
            c = 1'b0;
            if (r < 3) begin
                c = 1'b1; ph = 4'($urandom);
            end else if (r < 65) begin
                ph = (m_mode == 1) ? (4'b0001 << m_exp) : 4'b0001;
                if (ph == phase_in) ph = 4'b0000;
            end else if (r < 85) begin
                ph = phase_in;
            end else begin
                ph = 4'($urandom);
            end
            step(ph, c);
            n_checks++;
            if (obs !== mexp()) $display("FAIL random step%0d: got %h want %h", i, obs, mexp());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs !== '0) $display("FAIL reset_async: got %h want %h", obs, {VW{1'b0}});
        else n_pass++;
        #2 reset = 1'b1;
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b0);
        n_checks++;
        if ({locked, cycle_cnt, cur_phase} !== {1'b1, 4'd0, 2'd1})
            $display("FAIL reset_relock: got locked=%b cnt=%0d ph=%0d want 1 0 1", locked, cycle_cnt, cur_phase);
        else n_pass++;
        n_checks++;
        if (obs !== mexp()) $display("FAIL reset_model: got %h want %h", obs, mexp());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ring();
        test_order();
        test_collision();
        test_stall();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
